axi_request_gen_mc: RTL

//  Parametrised successor row-request generator. Emits a programmed number of

---
 rtl/reqgen_pkg.sv | 19 +
 rtl/reqgen_credit.sv | 44 ++++
 rtl/axi_request_gen_mc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/reqgen_pkg.sv
// reqgen_pkg
//  Shared definitions for the row-request generator: FSM state encoding,
//  the request address width and the default parameter values used by
//  axi_request_gen_mc and its credit sub-module.
package reqgen_pkg;

  localparam int ADDR_W              = 32;
  localparam int DEF_DATA_W          = 256;
  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_CNT_W           = 64;
  localparam int DEF_TIMEOUT_CYCLES  = 1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reqgen_state_e;

endpackage

// File: rtl/reqgen_credit.sv
// reqgen_credit
//  Tracks the number of requests in flight (handshaken but not yet completed)
//  and decides whether another request may be issued.
//  Ports:
//   clk, reset        clock, asynchronous active-high reset
//   clear             synchronous clear at the start of a run
//   send              a TX handshake happens this cycle
//   complete          a completion pulse seen while a run is active
//   outstanding       requests in flight
//   credit_ok         window not full (outstanding < MAX_OUTSTANDING)
//   complete_accept   completion is counted (ignored when nothing is in flight)
module reqgen_credit #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             send,
  input  logic             complete,
  output logic [OUT_W-1:0] outstanding,
  output logic             credit_ok,
  output logic             complete_accept
);

  // A completion with nothing in flight is a stray pulse; dropping it here
  // keeps completed <= sent in the top-level counters.
  assign complete_accept = complete && (outstanding != '0);
  assign credit_ok       = (outstanding < OUT_W'(MAX_OUTSTANDING));

  // Send and accepted completion in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (clear) begin
      outstanding <= '0;
    end else if (send && !complete_accept) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!send && complete_accept) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule

// File: rtl/axi_request_gen_mc.sv
// axi_request_gen_mc
//  Issues cfg_count address requests on an AXI-Stream TX port, address
//  n = cfg_base + n*cfg_stride (32-bit wrap), with TLAST on the final one.
//  A credit window limits requests in flight; row completions return credit.
//  After the last request the block drains until all completions are back.
//  Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort               1-cycle control pulses
//   cfg_count/base/stride      run configuration, latched on start
//   row_complete_in            one pulse per fulfilled request
//   idle_out, timeout_out      status
//   requests_sent/completed    per-run counters, kept after the run ends
//   AXIS_TX_*                  request stream, address in TDATA[31:0]
//  Build option: define REQGEN_TIMEOUT_EN to enable the completion watchdog
//  (TIMEOUT_CYCLES cycles without a completion while requests are in flight
//  sets timeout_out and aborts the run). Without it timeout_out is tied low.
module axi_request_gen_mc
  import reqgen_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_stride,
  input  logic              row_complete_in,
  output logic              idle_out,
  output logic              timeout_out,
  output logic [CNT_W-1:0]  requests_sent,
  output logic [CNT_W-1:0]  requests_completed,
  output logic [DATA_W-1:0] AXIS_TX_TDATA,
  output logic              AXIS_TX_TVALID,
  output logic              AXIS_TX_TLAST,
  input  logic              AXIS_TX_TREADY
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  reqgen_state_e     state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [15:0]       stride_q;
  logic [CNT_W-1:0]  sent_q, sent_d, completed_q, completed_d;
  logic [ADDR_W-1:0] addr_q, addr_d, tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic              abort_pend_q, abort_pend_d;

  logic              active, start_ok, handshake;
  logic              complete_accept, credit_ok, credit_ok_b2b;
  logic              timeout_fire;
  logic [OUT_W-1:0]  outstanding;

  assign active    = (state_q != IDLE);
  assign start_ok  = start && (state_q == IDLE) && (cfg_count != '0);
  assign handshake = tvalid_q && AXIS_TX_TREADY;

  reqgen_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OUT_W           (OUT_W)
  ) u_credit (
    .clk             (clk),
    .reset           (reset),
    .clear           (start_ok),
    .send            (handshake),
    .complete        (row_complete_in && active),
    .outstanding     (outstanding),
    .credit_ok       (credit_ok),
    .complete_accept (complete_accept)
  );

  // For a back-to-back beat the request handshaking now is not yet in the
  // outstanding count, so one extra slot must be free.
  assign credit_ok_b2b = (outstanding < OUT_W'(MAX_OUTSTANDING - 1));

`ifdef REQGEN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;
  logic            wd_counting;

  // The watchdog only runs while requests are in flight; every counted
  // completion restarts the window.
  assign wd_counting  = active && (outstanding != '0) && !complete_accept;
  assign timeout_fire = wd_counting && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_out  = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b1;
    end else if (wd_counting) begin
      wd_cnt_q  <= wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_q  <= '0;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_out  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and the registered TX beat.
  // A beat is loaded either into an empty output register or straight after
  // a handshake (back-to-back); its index is the post-update sent count.
  always_comb begin
    state_d      = state_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    addr_d       = addr_q;
    abort_pend_d = abort_pend_q;
    sent_d       = sent_q + CNT_W'(handshake);
    completed_d  = completed_q + CNT_W'(complete_accept);

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d      = RUN;
          sent_d       = '0;
          completed_d  = '0;
          addr_d       = cfg_base;
          abort_pend_d = 1'b0;
          tvalid_d     = 1'b0;
          tlast_d      = 1'b0;
        end
      end

      RUN: begin
        if (handshake) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        // A stalled beat must still complete before leaving on abort.
        if (abort || timeout_fire || abort_pend_q) begin
          if (tvalid_q && !AXIS_TX_TREADY) begin
            abort_pend_d = 1'b1;
          end else begin
            state_d      = IDLE;
            abort_pend_d = 1'b0;
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
          end
        end else if (handshake && tlast_q) begin
          state_d = DRAIN;
        end else if ((handshake && credit_ok_b2b) || (!tvalid_q && credit_ok)) begin
          tvalid_d = 1'b1;
          tdata_d  = addr_q;
          tlast_d  = (sent_d == count_q - CNT_W'(1));
          addr_d   = addr_q + ADDR_W'(stride_q);
        end
      end

      DRAIN: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (abort || timeout_fire || (completed_q == count_q)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers; configuration is captured only on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      stride_q     <= '0;
      sent_q       <= '0;
      completed_q  <= '0;
      addr_q       <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (start_ok) begin
        count_q  <= cfg_count;
        stride_q <= cfg_stride;
      end
      sent_q       <= sent_d;
      completed_q  <= completed_d;
      addr_q       <= addr_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign idle_out           = (state_q == IDLE);
  assign requests_sent      = sent_q;
  assign requests_completed = completed_q;
  assign AXIS_TX_TDATA      = DATA_W'(tdata_q);
  assign AXIS_TX_TVALID     = tvalid_q;
  assign AXIS_TX_TLAST      = tlast_q;

endmodule
